// File: rtl/pc_branch_unit_pkg.sv
// Shared control-word definitions: branch condition codes and request decode
// used by the program-counter / branch unit.
package pc_branch_unit_pkg;

  localparam int unsigned COND_WIDTH = 3;

  typedef enum logic [COND_WIDTH-1:0] {
    COND_ALWAYS = 3'd0,
    COND_Z      = 3'd1,
    COND_NZ     = 3'd2,
    COND_C      = 3'd3,
    COND_NC     = 3'd4,
    COND_ODD    = 3'd5,
    COND_EVEN   = 3'd6,
    COND_NEVER  = 3'd7
  } cond_e;

  typedef enum logic [2:0] {
    REQ_NONE = 3'd0,
    REQ_INC  = 3'd1,
    REQ_JUMP = 3'd2,
    REQ_CALL = 3'd3,
    REQ_RET  = 3'd4
  } req_e;

  // Priority select among simultaneous requests: ret > call > jump > inc.
  function automatic req_e req_select(input logic ret, input logic call,
                                      input logic jump, input logic inc);
    req_e sel;
    sel = REQ_NONE;
    if (ret) begin
      sel = REQ_RET;
    end else if (call) begin
      sel = REQ_CALL;
    end else if (jump) begin
      sel = REQ_JUMP;
    end else if (inc) begin
      sel = REQ_INC;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pc_branch_unit_call_stack.sv
// Return-address LIFO with registered occupancy flags. Entry storage is not
// reset; the read port returns zero while the stack is empty.
module call_stack #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] mem_q [STACK_DEPTH];

  logic             do_push_c;
  logic             do_pop_c;
  logic [PTR_W-1:0] wr_addr_c;
  logic [PTR_W-1:0] rd_addr_c;

  // Overflowing pushes and underflowing pops are dropped here as a safety net.
  always_comb begin
    do_push_c = push & ~full_q & ~pop;
    do_pop_c  = pop & ~empty_q & ~push;
    wr_addr_c = count_q[PTR_W-1:0];
    rd_addr_c = PTR_W'(count_q - CNT_W'(1));
    count_d   = count_q;
    if (do_push_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop_c) begin
      count_d = count_q - CNT_W'(1);
    end
    full_d  = (count_d == CNT_W'(STACK_DEPTH));
    empty_d = (count_d == CNT_W'(0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem_q[wr_addr_c] <= push_data;
    end
  end

  always_comb begin
    pop_data_c = empty_q ? '0 : mem_q[rd_addr_c];
  end

  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with conditional jump/call/return and a return-address
// stack; one step per enabled clock, sticky fault on stack over/underflow.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_inc,
  input  logic                  i_jump,
  input  logic                  i_call,
  input  logic                  i_ret,
  input  logic [COND_WIDTH-1:0] i_cond,
  input  logic [WIDTH-1:0]      i_target,
  input  logic                  i_zero,
  input  logic                  i_carry,
  input  logic                  i_odd,
  output logic [WIDTH-1:0]      o_pc,
  output logic                  o_taken,
  output logic                  o_stack_full,
  output logic                  o_stack_empty,
  output logic                  o_fault
);

  function automatic logic cond_met(input logic [COND_WIDTH-1:0] cond,
                                    input logic zero, input logic carry,
                                    input logic odd);
    logic met;
    met = 1'b0;
    case (cond_e'(cond))
      COND_ALWAYS: met = 1'b1;
      COND_Z:      met = zero;
      COND_NZ:     met = ~zero;
      COND_C:      met = carry;
      COND_NC:     met = ~carry;
      COND_ODD:    met = odd;
      COND_EVEN:   met = ~odd;
      COND_NEVER:  met = 1'b0;
      default:     met = 1'b0;
    endcase
    return met;
  endfunction

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             taken_q, taken_d;
  logic             fault_q, fault_d;

  logic [WIDTH-1:0] pc_inc_c;
  logic             cond_ok_c;
  req_e             req_c;
  logic             push_c;
  logic             pop_c;
  logic [WIDTH-1:0] pop_data_c;
  logic             stk_full;
  logic             stk_empty;

  call_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_call_stack (
    .clk        (clk),
    .rst        (rst),
    .push       (push_c),
    .pop        (pop_c),
    .push_data  (pc_inc_c),
    .pop_data_c (pop_data_c),
    .full       (stk_full),
    .empty      (stk_empty)
  );

  // Next-state: a disabled step leaves every register untouched.
  always_comb begin
    pc_d      = pc_q;
    taken_d   = taken_q;
    fault_d   = fault_q;
    push_c    = 1'b0;
    pop_c     = 1'b0;
    pc_inc_c  = pc_q + WIDTH'(1);
    cond_ok_c = cond_met(i_cond, i_zero, i_carry, i_odd);
    req_c     = req_select(i_ret, i_call, i_jump, i_inc);

    if (clk_en) begin
      taken_d = 1'b0;
      case (req_c)
        REQ_RET: begin
          if (cond_ok_c && !stk_empty) begin
            pc_d    = pop_data_c;
            pop_c   = 1'b1;
            taken_d = 1'b1;
          end else begin
            pc_d = pc_inc_c;
            if (cond_ok_c) begin
              fault_d = 1'b1;
            end
          end
        end
        REQ_CALL: begin
          if (cond_ok_c && !stk_full) begin
            pc_d    = i_target;
            push_c  = 1'b1;
            taken_d = 1'b1;
          end else begin
            pc_d = pc_inc_c;
            if (cond_ok_c) begin
              fault_d = 1'b1;
            end
          end
        end
        REQ_JUMP: begin
          if (cond_ok_c) begin
            pc_d    = i_target;
            taken_d = 1'b1;
          end else begin
            pc_d = pc_inc_c;
          end
        end
        REQ_INC:  pc_d = pc_inc_c;
        default:  pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      taken_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      fault_q <= fault_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_taken       = taken_q;
  assign o_fault       = fault_q;
  assign o_stack_full  = stk_full;
  assign o_stack_empty = stk_empty;

endmodule
